// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e       : responder state (CLEAR while zero-filling, SERVE afterwards)
//   DEPTH_DEFAULT : default number of 32-bit words
//   CNT_W_DEFAULT : default access-counter width
//   CORE_AW       : width of the core and host address buses
//   clog2()       : address width needed for a given depth
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  localparam int unsigned DEPTH_DEFAULT = 128;
  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned CORE_AW       = 7;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word store with one synchronous write port and one synchronous
// read port. The read port only updates its output register when re is high,
// so the last read value is held otherwise.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request and address
//   rdata        : registered read data
module dmem_array #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // NOTE: the array and its read register have no reset so the store maps onto
  // block RAM; the top level zero-fills the array and masks rdata after reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the core data-memory interface.
// After reset the store is zero-filled one word per cycle (CLEAR); then it
// serves one core access per cycle (SERVE) with a one-cycle registered read.
// A host preload port writes only on cycles the core leaves idle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   CEN/WEN/OEN         : core chip/write/output enables, active low
//   A, Data2Mem         : core word address and write data
//   ReadDataMem         : read data, forced to 0 while OEN is high
//   mem_ready           : high once the zero-fill has completed
//   init_valid/init_ready/init_addr/init_data : host preload handshake
//   rd_count, wr_count  : saturating counts of accepted core reads/writes
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               CEN,
  input  logic               WEN,
  input  logic               OEN,
  input  logic [CORE_AW-1:0] A,
  input  logic [31:0]        Data2Mem,
  output logic [31:0]        ReadDataMem,
  output logic               mem_ready,
  input  logic               init_valid,
  output logic               init_ready,
  input  logic [CORE_AW-1:0] init_addr,
  input  logic [31:0]        init_data,
  output logic [CNT_W-1:0]   rd_count,
  output logic [CNT_W-1:0]   wr_count
);

  localparam int unsigned AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [CORE_AW:0]  DEPTH_LIM = (CORE_AW + 1)'(DEPTH);
  localparam logic [AW-1:0]     LAST_PTR  = AW'(DEPTH - 1);

  state_e            state_q,     state_d;
  logic [AW-1:0]     clear_ptr_q, clear_ptr_d;
  logic              mem_ready_q, mem_ready_d;
  logic              zero_q,      zero_d;
  logic [CNT_W-1:0]  rd_cnt_q,    rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q,    wr_cnt_d;

  logic              serve;
  logic              core_rd, core_wr, init_xfer;
  logic              a_in_range, init_in_range;
  logic              arr_we;
  logic [AW-1:0]     arr_waddr;
  logic [31:0]       arr_wdata;
  logic [31:0]       arr_rdata;

  assign serve         = (state_q == ST_SERVE);
  assign core_rd       = serve & ~CEN &  WEN;
  assign core_wr       = serve & ~CEN & ~WEN;
  // The core has strict priority: the host is offered only idle core cycles.
  assign init_ready    = serve & CEN;
  assign init_xfer     = init_valid & init_ready;
  // Addresses at or above DEPTH alias nothing: writes drop, reads return 0.
  assign a_in_range    = ({1'b0, A} < DEPTH_LIM);
  assign init_in_range = ({1'b0, init_addr} < DEPTH_LIM);

  // Single write port, priority clear > core > host.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = '0;
    arr_wdata = '0;
    if (!serve) begin
      arr_we    = 1'b1;
      arr_waddr = clear_ptr_q;
    end else if (core_wr) begin
      arr_we    = a_in_range;
      arr_waddr = A[AW-1:0];
      arr_wdata = Data2Mem;
    end else if (init_xfer) begin
      arr_we    = init_in_range;
      arr_waddr = init_addr[AW-1:0];
      arr_wdata = init_data;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (core_rd & a_in_range),
    .raddr (A[AW-1:0]),
    .rdata (arr_rdata)
  );

  // Next-state logic for the FSM, clear pointer, read mask and counters.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    mem_ready_d = mem_ready_q;
    zero_d      = zero_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;

    if (!serve) begin
      clear_ptr_d = clear_ptr_q + AW'(1);
      if (clear_ptr_q == LAST_PTR) begin
        state_d     = ST_SERVE;
        mem_ready_d = 1'b1;
      end
    end

    // zero_q stands in for the unresettable array read register: it reads as
    // 0 after reset and after an out-of-range read, until an in-range read.
    if (core_rd) zero_d = ~a_in_range;

    if (core_rd && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    if (core_wr && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
      mem_ready_q <= 1'b0;
      zero_q      <= 1'b1;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      mem_ready_q <= mem_ready_d;
      zero_q      <= zero_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign mem_ready   = mem_ready_q;
  assign ReadDataMem = (OEN || zero_q) ? 32'h0 : arr_rdata;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (default DEPTH=128, CNT_W=16).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem;
  logic [31:0] ReadDataMem;
  logic        mem_ready;
  logic        init_valid;
  logic        init_ready;
  logic [6:0]  init_addr;
  logic [31:0] init_data;
  logic [15:0] rd_count, wr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .CEN         (CEN),
    .WEN         (WEN),
    .OEN         (OEN),
    .A           (A),
    .Data2Mem    (Data2Mem),
    .ReadDataMem (ReadDataMem),
    .mem_ready   (mem_ready),
    .init_valid  (init_valid),
    .init_ready  (init_ready),
    .init_addr   (init_addr),
    .init_data   (init_data),
    .rd_count    (rd_count),
    .wr_count    (wr_count)
  );

  typedef struct packed {
    logic        cen;
    logic        wen;
    logic        oen;
    logic [6:0]  a;
    logic [31:0] d;
    logic        iv;
    logic [6:0]  ia;
    logic [31:0] id;
    logic [31:0] exp_rdata;
    logic        exp_iready;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    CEN = 1'b1; WEN = 1'b1; A = '0; Data2Mem = '0;
    init_valid = 1'b0; init_addr = '0; init_data = '0;
  endtask

  task automatic core_read(input logic [6:0] addr);
    CEN = 1'b0; WEN = 1'b1; A = addr;
    tick();
    CEN = 1'b1;
  endtask

  initial begin
    int first_rdy;
    int cycles;

    //            cen  wen  oen  a     d             iv   ia    id            exp_rdata     ir   rd     wr
    vecs[0]  = '{1'b0,1'b0,1'b0,7'd3,  32'hDEADBEEF,1'b0,7'd0, 32'h0,        32'h00000000,1'b0,16'd2, 16'd1};
    vecs[1]  = '{1'b0,1'b1,1'b0,7'd3,  32'h0,       1'b0,7'd0, 32'h0,        32'hDEADBEEF,1'b0,16'd3, 16'd1};
    vecs[2]  = '{1'b1,1'b1,1'b1,7'd0,  32'h0,       1'b0,7'd0, 32'h0,        32'h00000000,1'b1,16'd3, 16'd1};
    vecs[3]  = '{1'b1,1'b1,1'b0,7'd0,  32'h0,       1'b0,7'd0, 32'h0,        32'hDEADBEEF,1'b1,16'd3, 16'd1};
    vecs[4]  = '{1'b0,1'b1,1'b0,7'd9,  32'h0,       1'b1,7'd9, 32'h12345678, 32'h00000000,1'b0,16'd4, 16'd1};
    vecs[5]  = '{1'b1,1'b1,1'b0,7'd0,  32'h0,       1'b1,7'd9, 32'h12345678, 32'h00000000,1'b1,16'd4, 16'd1};
    vecs[6]  = '{1'b0,1'b1,1'b0,7'd9,  32'h0,       1'b0,7'd0, 32'h0,        32'h12345678,1'b0,16'd5, 16'd1};
    vecs[7]  = '{1'b0,1'b0,1'b0,7'd127,32'hA5A5A5A5,1'b0,7'd0, 32'h0,        32'h12345678,1'b0,16'd5, 16'd2};
    vecs[8]  = '{1'b0,1'b1,1'b0,7'd127,32'h0,       1'b0,7'd0, 32'h0,        32'hA5A5A5A5,1'b0,16'd6, 16'd2};
    vecs[9]  = '{1'b0,1'b1,1'b0,7'd0,  32'h0,       1'b0,7'd0, 32'h0,        32'h00000000,1'b0,16'd7, 16'd2};
    vecs[10] = '{1'b0,1'b0,1'b0,7'd0,  32'h11111111,1'b1,7'd0, 32'h22222222, 32'h00000000,1'b0,16'd7, 16'd3};
    vecs[11] = '{1'b0,1'b1,1'b0,7'd0,  32'h0,       1'b0,7'd0, 32'h0,        32'h11111111,1'b0,16'd8, 16'd3};
    vecs[12] = '{1'b1,1'b1,1'b0,7'd0,  32'h0,       1'b1,7'd0, 32'h22222222, 32'h11111111,1'b1,16'd8, 16'd3};
    vecs[13] = '{1'b0,1'b1,1'b0,7'd0,  32'h0,       1'b0,7'd0, 32'h0,        32'h22222222,1'b0,16'd9, 16'd3};

    // Reset state
    rst_n = 1'b0;
    OEN   = 1'b0;
    idle();
    #12;
    check("rst_rdata",      ReadDataMem, 32'h0);
    check("rst_mem_ready",  32'(mem_ready), 32'h0);
    check("rst_init_ready", 32'(init_ready), 32'h0);
    check("rst_rd_count",   32'(rd_count), 32'h0);
    check("rst_wr_count",   32'(wr_count), 32'h0);

    // Clear timing, with a core write attempted at edge 10
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    first_rdy = 0;
    for (int i = 1; i <= 128; i++) begin
      if (i == 10) begin
        CEN = 1'b0; WEN = 1'b0; A = 7'd3; Data2Mem = 32'hFFFFFFFF;
      end
      if (i == 20) begin
        init_valid = 1'b1; init_addr = 7'd4; init_data = 32'hCAFEF00D;
        check("clear_init_ready", 32'(init_ready), 32'h0);
      end
      tick();
      if (i == 10) idle();
      if (i == 20) idle();
      if (mem_ready && first_rdy == 0) first_rdy = i;
      if (i == 127) check("ready_edge127", 32'(mem_ready), 32'h0);
      if (i == 128) check("ready_edge128", 32'(mem_ready), 32'h1);
    end
    check("ready_first_edge", 32'(first_rdy), 32'd128);
    check("clear_rd_count",   32'(rd_count), 32'h0);
    check("clear_wr_count",   32'(wr_count), 32'h0);
    check("clear_rdata_hold", ReadDataMem, 32'h0);

    core_read(7'd5);
    check("read_a5_zero", ReadDataMem, 32'h0);
    core_read(7'd3);
    check("read_a3_clear_write_ignored", ReadDataMem, 32'h0);
    core_read(7'd4);
    check("read_a4_clear_init_ignored", ReadDataMem, 32'h0);

    // Table-driven core/host vectors (counts continue from 3 reads above)
    for (int i = 0; i < 14; i++) begin
      vecs[i].exp_rd = vecs[i].exp_rd + 16'd1;
    end
    for (int i = 0; i < 14; i++) begin
      CEN = vecs[i].cen; WEN = vecs[i].wen; OEN = vecs[i].oen;
      A = vecs[i].a; Data2Mem = vecs[i].d;
      init_valid = vecs[i].iv; init_addr = vecs[i].ia; init_data = vecs[i].id;
      #1;
      check($sformatf("v%0d_init_ready", i), 32'(init_ready), 32'(vecs[i].exp_iready));
      tick();
      check($sformatf("v%0d_rdata", i),    ReadDataMem,     vecs[i].exp_rdata);
      check($sformatf("v%0d_rd_count", i), 32'(rd_count),   32'(vecs[i].exp_rd));
      check($sformatf("v%0d_wr_count", i), 32'(wr_count),   32'(vecs[i].exp_wr));
    end
    idle();
    OEN = 1'b0;

    // Read counter saturation
    CEN = 1'b0; WEN = 1'b1; A = 7'd3;
    repeat (65536) tick();
    check("sat_rd_count", 32'(rd_count), 32'h0000FFFF);
    tick();
    check("sat_rd_hold",  32'(rd_count), 32'h0000FFFF);
    check("sat_wr_count", 32'(wr_count), 32'd3);
    check("sat_rdata",    ReadDataMem,   32'hDEADBEEF);
    idle();

    // Asynchronous reset between edges
    rst_n = 1'b0;
    #2;
    check("arst_rdata",      ReadDataMem, 32'h0);
    check("arst_mem_ready",  32'(mem_ready), 32'h0);
    check("arst_init_ready", 32'(init_ready), 32'h0);
    check("arst_rd_count",   32'(rd_count), 32'h0);
    check("arst_wr_count",   32'(wr_count), 32'h0);
    #1;
    rst_n = 1'b1;
    cycles = 0;
    while (!mem_ready && cycles < 200) begin
      tick();
      cycles++;
    end
    check("reclear_edges", 32'(cycles), 32'd128);
    core_read(7'd3);
    check("reclear_a3_zero", ReadDataMem, 32'h0);
    core_read(7'd127);
    check("reclear_a127_zero", ReadDataMem, 32'h0);
    check("reclear_rd_count", 32'(rd_count), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
